// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC generator: next-PC source encoding
// and J-type target formation.
package pc_pkg;

    localparam int PC_STEP  = 4;
    localparam int MAX_XLEN = 64;

    // Listed in decreasing priority
    typedef enum logic [2:0] {
        NPC_REDIR,
        NPC_HOLD,
        NPC_JR,
        NPC_J,
        NPC_BR,
        NPC_SEQ
    } npc_src_e;

    // Keep the region bits of the sequential PC above the shifted jump field
    function automatic logic [MAX_XLEN-1:0] j_target(
        input logic [MAX_XLEN-1:0] seq_pc,
        input logic [MAX_XLEN-1:0] field,
        input int                  jaddr_w
    );
        logic [MAX_XLEN-1:0] low_mask;
        low_mask = (64'd1 << (jaddr_w + 2)) - 64'd1;
        return (seq_pc & ~low_mask) | ((field << 2) & low_mask);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty is ignored. The top of stack is read combinationally.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic            valid,
    output logic [XLEN-1:0] top
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  entries [DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] top_idx;
    logic             pop_ok;

    assign pop_ok  = pop && (count_reg != '0);
    assign top_idx = ptr_reg - PTR_W'(1);
    assign valid   = (count_reg != '0);
    assign top     = valid ? entries[top_idx] : '0;

    // The pointer wraps naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            if (count_reg != CNT_W'(DEPTH))
                count_reg <= count_reg + CNT_W'(1);
        end else if (pop_ok) begin
            ptr_reg   <= ptr_reg - PTR_W'(1);
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Storage has no reset; an empty stack is defined by count alone
    always_ff @(posedge clk) begin
        if (push)
            entries[ptr_reg] <= push_data;
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC register with prioritised next-PC selection and an optional
// return-address stack, enabled by defining PC_RAS_EN.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          JADDR_W   = 26,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               hold,
    input  logic               jump_reg,
    input  logic               is_ret,
    input  logic [XLEN-1:0]    tar_reg_addr,
    input  logic               jump,
    input  logic               link,
    input  logic [XLEN-1:0]    link_addr,
    input  logic [JADDR_W-1:0] tar_addr,
    input  logic               branch,
    input  logic [XLEN-1:0]    br_target,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus_4,
    output logic               ras_valid,
    output logic [XLEN-1:0]    ras_top
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] j_pc;
    logic [XLEN-1:0] jr_pc;
    npc_src_e        npc_src;

    assign pc        = pc_reg;
    assign pc_plus_4 = pc_reg + XLEN'(PC_STEP);
    assign j_pc      = XLEN'(j_target(MAX_XLEN'(pc_plus_4), MAX_XLEN'(tar_addr), JADDR_W));
    // ras_valid is tied low when the stack is not built, so this falls back to tar_reg_addr
    assign jr_pc     = (is_ret && ras_valid) ? ras_top : tar_reg_addr;

    always_comb begin
        npc_src = NPC_SEQ;
        if (redirect)
            npc_src = NPC_REDIR;
        else if (hold)
            npc_src = NPC_HOLD;
        else if (jump_reg)
            npc_src = NPC_JR;
        else if (jump)
            npc_src = NPC_J;
        else if (branch)
            npc_src = NPC_BR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_VEC;
        end else begin
            case (npc_src)
                NPC_REDIR: pc_reg <= redirect_pc;
                NPC_HOLD:  pc_reg <= pc_reg;
                NPC_JR:    pc_reg <= jr_pc;
                NPC_J:     pc_reg <= j_pc;
                NPC_BR:    pc_reg <= br_target;
                default:   pc_reg <= pc_plus_4;
            endcase
        end
    end

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop;

    // Only the winning source may touch the stack
    assign ras_push = (npc_src == NPC_J)  && link;
    assign ras_pop  = (npc_src == NPC_JR) && is_ret;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .valid     (ras_valid),
        .top       (ras_top)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{link, link_addr};
    assign ras_valid         = 1'b0;
    assign ras_top           = '0;
`endif

endmodule

// File: tb/tb_pc_gen_ras.sv
// Self-checking bench for pc_gen_ras: directed scenarios plus randomized traffic
// compared against a queue-based reference model. Follows PC_RAS_EN like the RTL.
module tb_pc_gen_ras;

    localparam int          XLEN      = 32;
    localparam int          JADDR_W   = 26;
    localparam logic [31:0] RESET_VEC = 32'h100;
    localparam int          RAS_DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              hold;
    logic              jump_reg;
    logic              is_ret;
    logic [31:0]       tar_reg_addr;
    logic              jump;
    logic              link;
    logic [31:0]       link_addr;
    logic [25:0]       tar_addr;
    logic              branch;
    logic [31:0]       br_target;
    logic [31:0]       pc;
    logic [31:0]       pc_plus_4;
    logic              ras_valid;
    logic [31:0]       ras_top;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    pc_gen_ras #(
        .XLEN      (XLEN),
        .JADDR_W   (JADDR_W),
        .RESET_VEC (RESET_VEC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .hold         (hold),
        .jump_reg     (jump_reg),
        .is_ret       (is_ret),
        .tar_reg_addr (tar_reg_addr),
        .jump         (jump),
        .link         (link),
        .link_addr    (link_addr),
        .tar_addr     (tar_addr),
        .branch       (branch),
        .br_target    (br_target),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .ras_valid    (ras_valid),
        .ras_top      (ras_top)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc4"}, pc_plus_4, m_pc + 32'd4);
        check({tag, ".ras_valid"}, {31'd0, ras_valid}, {31'd0, m_ras.size() > 0});
        check({tag, ".ras_top"}, ras_top, (m_ras.size() > 0) ? m_ras[$] : 32'd0);
    endtask

    task automatic clear_inputs();
        redirect = 0; redirect_pc = 0; hold = 0; jump_reg = 0; is_ret = 0;
        tar_reg_addr = 0; jump = 0; link = 0; link_addr = 0; tar_addr = 0;
        branch = 0; br_target = 0;
    endtask

    // Reference next-PC: priority list, RAS as a bounded stack of return addresses
    task automatic cycle(input string tag);
        logic [31:0] nxt;
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (redirect)
            nxt = redirect_pc;
        else if (hold)
            nxt = m_pc;
        else if (jump_reg) begin
            if (RAS_EN && is_ret && m_ras.size() > 0)
                nxt = m_ras.pop_back();
            else
                nxt = tar_reg_addr;
        end else if (jump) begin
            nxt = (seq & 32'hF000_0000) | ({6'd0, tar_addr} * 4);
            if (RAS_EN && link) begin
                m_ras.push_back(link_addr);
                if (m_ras.size() > RAS_DEPTH)
                    void'(m_ras.pop_front());
            end
        end else if (branch)
            nxt = br_target;
        else
            nxt = seq;
        @(posedge clk);
        #1;
        m_pc = nxt;
        cyc++;
        $display("cyc %0d %s pc=%h exp=%h ras_valid=%0b ras_top=%h", cyc, tag, pc, m_pc, ras_valid, ras_top);
        check_all(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_pc = RESET_VEC;
        m_ras.delete();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) cycle("idle");

        // Asynchronous reset mid-run takes effect without a clock edge
        cycle("idle");
        #2;
        rst = 1'b1;
        #1;
        m_pc = RESET_VEC;
        m_ras.delete();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;

        clear_inputs(); redirect = 1; redirect_pc = 32'h1000_0040;
        cycle("redir");
        clear_inputs(); jump = 1; tar_addr = 26'h00_0010;
        cycle("jump");
        check("jump_abs", pc, 32'h1000_0040);
        clear_inputs(); hold = 1; redirect = 1; redirect_pc = 32'h80;
        cycle("hold_redir");
        check("hold_redir_abs", pc, 32'h80);
        clear_inputs(); hold = 1;
        cycle("hold");

        clear_inputs(); jump = 1; link = 1; link_addr = 32'h77; branch = 1;
        br_target = 32'h300; jump_reg = 1; tar_reg_addr = 32'h200;
        cycle("prio_jr");
        check("prio_abs", pc, 32'h200);

        clear_inputs(); jump = 1; link = 1; link_addr = 32'h44; tar_addr = 26'h40;
        cycle("jal");
        clear_inputs(); jump_reg = 1; is_ret = 1; tar_reg_addr = 32'h99;
        cycle("ret");
        check("ret_abs", pc, RAS_EN ? 32'h44 : 32'h99);

        for (int k = 1; k <= 5; k++) begin
            clear_inputs(); jump = 1; link = 1; link_addr = 32'h10 * k; tar_addr = 26'h100;
            cycle("push");
        end
        for (int k = 0; k < 5; k++) begin
            clear_inputs(); jump_reg = 1; is_ret = 1; tar_reg_addr = 32'h999;
            cycle("pop");
        end
        check("pop_empty_abs", pc, 32'h999);

        clear_inputs(); branch = 1; br_target = 32'h2468;
        cycle("branch");
        clear_inputs(); redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        cycle("redir_top");
        clear_inputs();
        cycle("wrap");
        check("wrap_abs", pc, 32'h0);

        for (int i = 0; i < 400; i++) begin
            redirect     = ($urandom_range(0, 19) == 0);
            redirect_pc  = $urandom;
            hold         = ($urandom_range(0, 9) == 0);
            jump_reg     = ($urandom_range(0, 3) == 0);
            is_ret       = $urandom_range(0, 1) == 1;
            tar_reg_addr = $urandom;
            jump         = ($urandom_range(0, 2) == 0);
            link         = $urandom_range(0, 1) == 1;
            link_addr    = $urandom;
            tar_addr     = 26'($urandom);
            branch       = ($urandom_range(0, 3) == 0);
            br_target    = $urandom;
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
